// File: rtl/seg_odometer.sv
// Parametrised BCD odometer with wrap/saturate boundary and a two-bus multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining SEG_ODO_LZ_BLANK_EN.
module seg_odometer #(
    parameter int DIGITS = 8,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  run,
    input  logic                  clr,
    input  logic                  count_tick,
    input  logic                  scan_tick,
    input  logic [DIGITS-1:0]     dp,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  sat,
    output logic [DIGITS-1:0]     seg_en,
    output logic [7:0]            seg_out0,
    output logic [7:0]            seg_out1
);

    localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int HALF  = DIGITS / 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(HALF);

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'b1111_1100;
            4'd1:    seg7 = 8'b0110_0000;
            4'd2:    seg7 = 8'b1101_1010;
            4'd3:    seg7 = 8'b1111_0010;
            4'd4:    seg7 = 8'b0110_0110;
            4'd5:    seg7 = 8'b1011_0110;
            4'd6:    seg7 = 8'b1011_1110;
            4'd7:    seg7 = 8'b1110_0000;
            4'd8:    seg7 = 8'b1111_1110;
            4'd9:    seg7 = 8'b1111_0110;
            default: seg7 = 8'b0000_0000;
        endcase
    endfunction

    function automatic logic all_nines(input logic [4*DIGITS-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r & (v[4*i +: 4] == 4'd9);
        end
        return r;
    endfunction

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                sat_q, sat_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   seg_en_q, seg_en_d;
    logic [7:0]          seg_out0_q, seg_out0_d;
    logic [7:0]          seg_out1_q, seg_out1_d;

    logic [DIGITS-1:0]   blank_s;
    logic [3:0]          digit_s;
    logic [7:0]          glyph_s;
    logic [7:0]          pattern_s;
    logic                upper_s;

    // Counter next state: clear beats increment; the carry ripples through trailing 9s.
    always_comb begin
        logic carry;
        bcd_d = bcd_q;
        ovf_d = 1'b0;
        carry = 1'b1;
        if (clr) begin
            bcd_d = {(4*DIGITS){1'b0}};
        end else if (run && count_tick) begin
            if (all_nines(bcd_q)) begin
                if (WRAP) begin
                    bcd_d = {(4*DIGITS){1'b0}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = bcd_q;
                end
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (bcd_q[4*i +: 4] == 4'd9) begin
                            bcd_d[4*i +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4];
                    end
                end
            end
        end else begin
            bcd_d = bcd_q;
        end
        sat_d = WRAP ? 1'b0 : all_nines(bcd_d);
    end

    // Scan index: held at digit 0 while the display is unpowered.
    always_comb begin
        if (!en) begin
            idx_d = {IDX_W{1'b0}};
        end else if (scan_tick) begin
            idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_d = idx_q;
        end
    end

`ifdef SEG_ODO_LZ_BLANK_EN
    // A digit blanks when it and everything above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (bcd_q[4*i +: 4] == 4'd0);
            blank_s[i] = (i != 0) && zero_above;
        end
    end
`else
    // Blanking disabled: every digit shows its numeral.
    always_comb begin
        blank_s = {DIGITS{1'b0}};
    end
`endif

    // Display next state: select, glyph and bus steering all derive from the same idx_q.
    always_comb begin
        digit_s   = bcd_q[{idx_q, 2'b00} +: 4];
        glyph_s   = seg7(digit_s);
        pattern_s = {(blank_s[idx_q] ? 7'b000_0000 : glyph_s[7:1]), dp[idx_q]};
        upper_s   = (idx_q >= IDX_HALF);
        if (en) begin
            seg_en_d   = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
            seg_out0_d = upper_s ? pattern_s : 8'h00;
            seg_out1_d = upper_s ? 8'h00 : pattern_s;
        end else begin
            seg_en_d   = {DIGITS{1'b0}};
            seg_out0_d = 8'h00;
            seg_out1_d = 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q      <= {(4*DIGITS){1'b0}};
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            seg_en_q   <= {DIGITS{1'b0}};
            seg_out0_q <= 8'h00;
            seg_out1_q <= 8'h00;
        end else begin
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
            idx_q      <= idx_d;
            seg_en_q   <= seg_en_d;
            seg_out0_q <= seg_out0_d;
            seg_out1_q <= seg_out1_d;
        end
    end

    assign bcd      = bcd_q;
    assign ovf      = ovf_q;
    assign sat      = sat_q;
    assign seg_en   = seg_en_q;
    assign seg_out0 = seg_out0_q;
    assign seg_out1 = seg_out1_q;

endmodule
